// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX among N_REQ byte sources.
// Optional watchdog on WAIT_DONE: define UART_ARB_TIMEOUT_EN.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_req, i_data    per-requester pending flag and flattened bytes
//   o_ack            one-hot pulse, byte of requester k consumed
//   o_tx_data        byte for the transmitter (held until next grant)
//   o_tx_start       one-cycle transmitter start pulse
//   i_tx_done        one-cycle pulse, stop bit finished
//   o_owner          requester owning the current/last frame
//   o_busy           high in every state except IDLE
//   o_timeout        watchdog pulse (0 without UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 50000,
  localparam int OWNER_W    = $clog2(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  output logic [N_REQ-1:0]     o_ack,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  input  logic                 i_tx_done,
  output logic [OWNER_W-1:0]   o_owner,
  output logic                 o_busy,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [15:0]        gap_q, gap_d;
  logic [N_REQ-1:0]   ack_d;
  logic [7:0]         data_d;
  logic [OWNER_W-1:0] owner_d;
  logic               start_d;
  logic               busy_d;
  logic               tmo_hit;

  logic               found;
  int                 widx;
  int                 idx;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic        tmo_q, tmo_d;

  // Counter restarts while in START so it is zero on WAIT_DONE entry.
  always_comb begin
    tcnt_d = tcnt_q;
    tmo_d  = 1'b0;
    if (state_q == S_START) begin
      tcnt_d = '0;
    end else if (state_q == S_WAIT && !i_tx_done) begin
      if (tcnt_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
        tmo_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo_hit   = tmo_d;
  assign o_timeout = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    widx  = 0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && i_req[idx]) begin
        found = 1'b1;
        widx  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = o_tx_data;
    owner_d = o_owner;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ack_d[widx] = 1'b1;
          data_d      = i_data[8*widx +: 8];
          owner_d     = OWNER_W'(widx);
          ptr_d       = OWNER_W'(widx);
          state_d     = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done || tmo_hit) begin
          if (GAP_CYC == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = 16'(GAP_CYC);
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q == 16'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= OWNER_W'(N_REQ - 1);
      gap_q      <= '0;
      o_ack      <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_owner    <= '0;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gap_q      <= gap_d;
      o_ack      <= ack_d;
      o_tx_data  <= data_d;
      o_tx_start <= start_d;
      o_owner    <= owner_d;
      o_busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Main DUT uses GAP_CYC=2; a second instance checks GAP_CYC=0 timing.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, req0;
  logic [31:0] data;
  logic        done, done0;
  logic [3:0]  ack, ack0;
  logic [7:0]  txd, txd0;
  logic        start, start0;
  logic [1:0]  owner, owner0;
  logic        busy, busy0;
  logic        tmo, tmo0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t em, em0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYC(2), .TIMEOUT_CYC(20)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_data(data),
    .o_ack(ack), .o_tx_data(txd), .o_tx_start(start),
    .i_tx_done(done), .o_owner(owner), .o_busy(busy),
    .o_timeout(tmo)
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYC(0), .TIMEOUT_CYC(20)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_req(req0), .i_data(data),
    .o_ack(ack0), .o_tx_data(txd0), .o_tx_start(start0),
    .i_tx_done(done0), .o_owner(owner0), .o_busy(busy0),
    .o_timeout(tmo0)
  );

  // Scoreboard monitors: one per instance.
  always @(negedge clk) begin
    if (|ack) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL grant_unexpected ack=%b owner=%0d", ack, owner);
      end else begin
        em = q.pop_front();
        if (ack !== (4'b0001 << em.owner) || txd !== em.data ||
            owner !== em.owner || start !== 1'b0) begin
          failures++;
          $display("FAIL grant got ack=%b data=%h owner=%0d start=%b exp owner=%0d data=%h",
                   ack, txd, owner, start, em.owner, em.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (|ack0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL grant0_unexpected ack=%b owner=%0d", ack0, owner0);
      end else begin
        em0 = q0.pop_front();
        if (ack0 !== (4'b0001 << em0.owner) || txd0 !== em0.data ||
            owner0 !== em0.owner) begin
          failures++;
          $display("FAIL grant0 got ack=%b data=%h owner=%0d exp owner=%0d data=%h",
                   ack0, txd0, owner0, em0.owner, em0.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    q.push_back(e);
  endtask

  task automatic push0(input logic [1:0] o, input logic [7:0] d);
    exp_t e;
    e.owner = o;
    e.data  = d;
    q0.push_back(e);
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic run_frame(input bit drop);
    wait_start("frame_start");
    if (drop) req = '0;
    repeat (10) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    rst   = 1'b1;
    req   = '0;
    req0  = '0;
    done  = 1'b0;
    done0 = 1'b0;
    data  = 32'h0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_ack", 32'(ack), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner_data", {22'd0, owner, txd}, 32'd0);

    // Single request
    data[23:16] = 8'hA5;
    req = 4'b0100;
    push(2'd2, 8'hA5);
    tick();
    check("single_ack", 32'(ack), 32'h4);
    req = '0;
    check("single_nostart", 32'(start), 32'd0);
    tick();
    check("single_start", 32'(start), 32'd1);
    check("single_ack_clr", 32'(ack), 32'd0);
    tick();
    check("single_start_1cyc", 32'(start), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    check("gap_busy_e2", 32'(busy), 32'd1);
    tick();
    check("gap_busy_e3", 32'(busy), 32'd0);

    // Fairness from fresh reset
    do_reset();
    data = 32'h43322110;
    req  = 4'b1111;
    push(2'd0, 8'h10);
    push(2'd1, 8'h21);
    push(2'd2, 8'h32);
    push(2'd3, 8'h43);
    push(2'd0, 8'h10);
    for (int k = 0; k < 5; k++) run_frame(k == 4);
    wait_idle("fair_idle");

    // Wrap priority: grant 1, then 0011 -> 0, 1
    req = 4'b0010;
    push(2'd1, 8'h21);
    run_frame(1'b1);
    wait_idle("wrap_idle1");
    req = 4'b0011;
    push(2'd0, 8'h10);
    push(2'd1, 8'h21);
    run_frame(1'b0);
    run_frame(1'b1);
    wait_idle("wrap_idle2");

    // Reset mid-frame
    req = 4'b1000;
    push(2'd3, 8'h43);
    wait_start("rst_frame_start");
    req = '0;
    tick();
    rst = 1'b1;
    req = 4'b1000;
    tick();
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_owner_data", {22'd0, owner, txd}, 32'd0);
    rst  = 1'b0;
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    check("idle_done_ignored", 32'(busy), 32'd0);
    tick();
    check("idle_done_nostart", {30'd0, start, busy}, 32'd0);
    req = 4'b1000;
    push(2'd3, 8'h43);
    tick();
    req = '0;
    run_frame(1'b0);
    wait_idle("midrst_idle");

    // Back-to-back on the GAP_CYC=0 instance
    req0 = 4'b0011;
    push0(2'd0, 8'h10);
    push0(2'd1, 8'h21);
    tick();
    req0 = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (start0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("b2b_start", 32'(ok), 32'd1);
    repeat (3) tick();
    done0 = 1'b1;
    tick();
    done0 = 1'b0;
    check("b2b_not_early", 32'(ack0), 32'd0);
    tick();
    check("b2b_second_ack", 32'(ack0), 32'h2);
    req0 = '0;

    // Stuck transmitter
    req = 4'b0001;
    push(2'd0, 8'h10);
    wait_start("stuck_start");
    req = '0;
`ifdef UART_ARB_TIMEOUT_EN
    ok = 1'b1;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (tmo) ok = 1'b0;
    end
    check("tmo_not_early", 32'(ok), 32'd1);
    tick();
    check("tmo_pulse", 32'(tmo), 32'd1);
    tick();
    check("tmo_one_cycle", 32'(tmo), 32'd0);
    wait_idle("tmo_idle");
`else
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!busy || tmo) ok = 1'b0;
    end
    check("busy_hold_1000", 32'(ok), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_idle("hold_idle");
`endif

    repeat (5) tick();
    check("sb_drained", 32'(q.size()), 32'd0);
    check("sb0_drained", 32'(q0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among up to eight byte-producing requesters. It sits between the requester logic (command responders, status reporters, loopback from the receiver) and the single UART TX datapath. For each byte it picks a requester, latches that requester's byte and acknowledges it. It then pulses the transmitter start, waits for the frame-done pulse, and enforces a programmable inter-frame idle gap before the next grant.

## Interface
- N_REQ, 4: number of requesters, legal 2..8.
- GAP_CYC, 16: i_clk cycles of forced idle after each frame, legal 0..65535.
- TIMEOUT_CYC, 50000: watchdog limit in WAIT_DONE, legal 1..65535. Used only when UART_ARB_TIMEOUT_EN is defined.
- OWNER_W (localparam): $clog2(N_REQ).

Ports:
- i_clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  per-requester byte-pending flags.
- i_data  in  8*N_REQ  flattened bytes; requester k uses [8k+7:8k].
- o_ack  out  N_REQ  one-hot, one-cycle pulse: byte of requester k was consumed.
- o_tx_data  out  8  byte presented to the transmitter.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- i_tx_done  in  1  one-cycle pulse from the transmitter: stop bit finished.
- o_owner  out  OWNER_W  index of the requester that owns the current or last frame.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle watchdog pulse; tied 0 when the macro is absent.

## Operation
- FSM states: IDLE, START, WAIT_DONE, GAP. All outputs are registered.
- Reset (synchronous, any state):
  - state=IDLE; all outputs = 0.
  - Round-robin pointer ptr = N_REQ-1, so requester 0 has top priority first.
  - Gap counter and timeout counter = 0.
- IDLE, with any i_req bit set:
  - Winner k = first set bit searching ptr+1, ptr+2, …, wrapping modulo N_REQ.
  - Same edge: o_ack[k]=1, o_tx_data=i_data[k], o_owner=k, ptr=k, state→START.
- IDLE, with i_req=0: hold state.
- START: o_tx_start=1 for exactly one cycle; state→WAIT_DONE.
- WAIT_DONE:
  - On i_tx_done=1: state→GAP, gap counter loaded with GAP_CYC. If GAP_CYC=0, state→IDLE instead.
  - i_tx_done in any other state is ignored.
- GAP: decrement the counter each cycle; state→IDLE on the cycle it reaches 0.
- i_req is sampled only in IDLE. A requester holds i_req and its i_data stable until its o_ack. A request still high on the ack cycle counts as a new byte and is re-arbitrated at the next IDLE.
- o_tx_data and o_owner hold their value until the next grant.
- Only one o_ack bit is ever high. o_ack and o_tx_start are never high in the same cycle.

## Timing
- Request high in IDLE at edge E0 → o_ack visible after E0 → o_tx_start visible after E1 (one cycle after ack).
- i_tx_done sampled at edge Ed → next grant at Ed+GAP_CYC+1 at the earliest. With GAP_CYC=0, the next o_ack follows the done pulse by 2 edges.
- Requester service bound while continuously requesting: at most N_REQ-1 other frames between two of its grants.
- An i_tx_done arriving in the same cycle that o_tx_start is high (state already WAIT_DONE) is accepted.
- Reset asserted mid-frame: o_tx_start and o_busy are 0 after that edge. The transmitter is not aborted by this block.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYC without i_tx_done: o_timeout pulses one cycle and state→GAP, with the same gap rules as a normal frame end.
  - If i_tx_done and the limit coincide, done wins and no timeout pulse occurs.
- UART_ARB_TIMEOUT_EN undefined: no counter; o_timeout is constant 0; WAIT_DONE waits indefinitely for i_tx_done.

## Test plan
- Single request: N_REQ=4, GAP_CYC=2, i_req=4'b0100, i_data[23:16]=8'hA5.
  - Required: o_ack=4'b0100 for one cycle; o_tx_data=8'hA5 and o_owner=2.
  - o_tx_start one cycle later.
  - After an i_tx_done pulse: o_busy falls 3 edges later.
- Fairness: i_req=4'b1111 held, i_tx_done pulsed 10 cycles after each o_tx_start → grant order 0,1,2,3,0. o_tx_data follows the per-requester bytes 8'h10,8'h21,8'h32,8'h43.
- Wrap priority: after a grant to requester 1, i_req=4'b0011 → next grant is requester 0, then requester 1.
- Back-to-back: GAP_CYC=0, two requesters pending → second o_ack exactly 2 edges after the first i_tx_done.
- Reset mid-frame: i_reset pulsed in WAIT_DONE with i_req=4'b1000.
  - Outputs are 0 after that edge.
  - Next grant goes to requester 3 (search starts from requester 0 after reset, which wraps to 3); any i_tx_done in IDLE is ignored.
- Timeout: macro defined, TIMEOUT_CYC=20, no i_tx_done.
  - o_timeout pulses on the 20th WAIT_DONE cycle, then GAP→IDLE.
  - With the macro undefined: o_busy stays 1 for 1000 cycles.
